mac_operand_sequencer: RTL and testbench

//   Upstream feeder for tt_um_mac. Buffers operand pairs (A,B) in a small FIFO and

---
 rtl/mac_operand_sequencer.sv | 157 +++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers (A,B) operand pairs in a small FIFO and issues
// them to the MAC as one vector of programmable length, flagging the first
// element (accumulator clear) and the last, then pulsing done.
// Optional feature macro: ZERO_SKIP_EN (drop interior pairs with a zero operand).
module mac_operand_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEN_W-1:0]         vec_len,
  input  logic                     start,
  output logic [DATA_W-1:0]        mac_a,
  output logic [DATA_W-1:0]        mac_b,
  output logic                     mac_valid,
  output logic                     mac_clr,
  output logic                     mac_last,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [DATA_W-1:0]       a_mem [DEPTH];
  logic [DATA_W-1:0]       b_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len;

  logic                    push_c;
  logic                    pop_c;
  logic                    issue_c;
  logic                    is_first_c;
  logic                    is_last_c;
  logic                    start_ok_c;
  logic [DATA_W-1:0]       head_a_c;
  logic [DATA_W-1:0]       head_b_c;

  // Upstream handshake: full FIFO refuses a push even if it pops this cycle.
  assign in_ready   = ena && (level != LVL_W'(DEPTH));
  assign push_c     = in_valid && in_ready;
  assign head_a_c   = a_mem[rd_ptr];
  assign head_b_c   = b_mem[rd_ptr];
  assign is_first_c = (cnt == '0);
  assign is_last_c  = (cnt == len - LEN_W'(1));
  assign start_ok_c = (state == IDLE) && start && ena;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE lingers while ena is low so done is not lost.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok_c) state_nxt = (vec_len != '0) ? RUN : DONE;
      RUN:  if (pop_c && is_last_c) state_nxt = DONE;
      DONE: if (ena) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop/issue decisions and status decode.
  always_comb begin
    pop_c   = 1'b0;
    issue_c = 1'b0;
    busy    = (state != IDLE);
    done    = (state == DONE) && ena;
    if (state == RUN && ena && level != '0) begin
      pop_c = 1'b1;
`ifdef ZERO_SKIP_EN
      issue_c = is_first_c || is_last_c ||
                ((head_a_c != '0) && (head_b_c != '0));
`else
      issue_c = 1'b1;
`endif
    end
  end

  // FIFO storage; contents are don't-care until level says otherwise.
  always_ff @(posedge clk) begin
    if (push_c) begin
      a_mem[wr_ptr] <= in_a;
      b_mem[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; written words become visible next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Vector length latch and element counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      len <= '0;
    end else if (start_ok_c) begin
      cnt <= '0;
      len <= vec_len;
    end else if (pop_c) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  // MAC operand register; operands hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mac_a     <= '0;
      mac_b     <= '0;
      mac_valid <= 1'b0;
      mac_clr   <= 1'b0;
      mac_last  <= 1'b0;
    end else begin
      mac_valid <= pop_c && issue_c;
      mac_clr   <= pop_c && issue_c && is_first_c;
      mac_last  <= pop_c && issue_c && is_last_c;
      if (pop_c && issue_c) begin
        mac_a <= head_a_c;
        mac_b <= head_b_c;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with an expected-issue scoreboard.
module tb_mac_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] vec_len;
  logic       start;
  logic [7:0] mac_a;
  logic [7:0] mac_b;
  logic       mac_valid;
  logic       mac_clr;
  logic       mac_last;
  logic       busy;
  logic       done;
  logic [2:0] level;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issued = 0;
  int   done_cnt = 0;
  int   done_last_cnt = 0;
  int   first_issue = -1;
  int   last_issue = -1;
  int   base;

  mac_operand_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_len   (vec_len),
    .start     (start),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_valid (mac_valid),
    .mac_clr   (mac_clr),
    .mac_last  (mac_last),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and score any issued element.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (mac_valid) begin
      issued++;
      if (first_issue < 0) first_issue = cyc;
      last_issue = cyc;
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mac_a", 32'(mac_a), 32'(e.a));
        chk("mac_b", 32'(mac_b), 32'(e.b));
        chk("mac_clr", 32'(mac_clr), 32'(e.clr));
        chk("mac_last", 32'(mac_last), 32'(e.last));
      end
    end else begin
      chk("flags_idle", 32'({mac_clr, mac_last}), 32'd0);
    end
    if (done) begin
      done_cnt++;
      if (mac_valid && mac_last) done_last_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [7:0] a, input logic [7:0] b,
                              input logic clr, input logic last);
    exp_t e;
    e.a = a; e.b = b; e.clr = clr; e.last = last;
    sb.push_back(e);
  endtask

  task automatic go(input logic [3:0] n);
    vec_len = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_a = '0; in_b = '0; in_valid = 1'b0;
    vec_len = '0; start = 1'b0;

    // 1: reset state
    run(2);
    chk("rst_mac_valid", 32'(mac_valid), 32'd0);
    chk("rst_mac_ab", 32'({mac_a, mac_b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2: basic 4-element vector
    expect_issue(8'd3, 8'd2, 1'b1, 1'b0);
    expect_issue(8'd1, 8'd4, 1'b0, 1'b0);
    expect_issue(8'd5, 8'd3, 1'b0, 1'b0);
    expect_issue(8'd7, 8'd2, 1'b0, 1'b1);
    push(8'd3, 8'd2); push(8'd1, 8'd4); push(8'd5, 8'd3); push(8'd7, 8'd2);
    chk("t2_level", 32'(level), 32'd4);
    first_issue = -1;
    go(4'd4);
    chk("t2_busy_run", 32'(busy), 32'd1);
    run(8);
    chk("t2_issued", 32'(issued), 32'd4);
    chk("t2_consecutive", 32'(last_issue - first_issue), 32'd3);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_done_with_last", 32'(done_last_cnt), 32'd1);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_hold_a", 32'(mac_a), 32'd7);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: overfill in IDLE, fifth pair dropped
    expect_issue(8'd11, 8'd1, 1'b1, 1'b0);
    expect_issue(8'd12, 8'd2, 1'b0, 1'b0);
    expect_issue(8'd13, 8'd3, 1'b0, 1'b0);
    expect_issue(8'd14, 8'd4, 1'b0, 1'b1);
    push(8'd11, 8'd1); push(8'd12, 8'd2); push(8'd13, 8'd3); push(8'd14, 8'd4);
    push(8'd15, 8'd5);
    chk("t3_level_full", 32'(level), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    base = issued;
    go(4'd4);
    run(8);
    chk("t3_issued", 32'(issued - base), 32'd4);
    chk("t3_level_after", 32'(level), 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: zero-length vector
    base = issued;
    go(4'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_valid", 32'(mac_valid), 32'd0);
    tick();
    chk("t4_done_off", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_issue", 32'(issued - base), 32'd0);

    // 5: reset mid-vector, then a new vector waits for pushes
    expect_issue(8'd21, 8'd1, 1'b1, 1'b0);
    expect_issue(8'd22, 8'd2, 1'b0, 1'b0);
    push(8'd21, 8'd1); push(8'd22, 8'd2); push(8'd23, 8'd3); push(8'd24, 8'd4);
    base = issued;
    go(4'd4);
    run(2);
    chk("t5_two_issued", 32'(issued - base), 32'd2);
    rst_n = 1'b0;
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_valid", 32'(mac_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    base = issued;
    go(4'd2);
    run(4);
    chk("t5_waiting", 32'(issued - base), 32'd0);
    chk("t5_busy_wait", 32'(busy), 32'd1);
    expect_issue(8'd9, 8'd9, 1'b1, 1'b0);
    expect_issue(8'd8, 8'd8, 1'b0, 1'b1);
    push(8'd9, 8'd9); push(8'd8, 8'd8);
    run(6);
    chk("t5_issued_new", 32'(issued - base), 32'd2);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: zero operands
`ifdef ZERO_SKIP_EN
    expect_issue(8'd3, 8'd2, 1'b1, 1'b0);
    expect_issue(8'd7, 8'd2, 1'b0, 1'b1);
`else
    expect_issue(8'd3, 8'd2, 1'b1, 1'b0);
    expect_issue(8'd0, 8'd4, 1'b0, 1'b0);
    expect_issue(8'd5, 8'd0, 1'b0, 1'b0);
    expect_issue(8'd7, 8'd2, 1'b0, 1'b1);
`endif
    push(8'd3, 8'd2); push(8'd0, 8'd4); push(8'd5, 8'd0); push(8'd7, 8'd2);
    base = issued;
    done_cnt = 0;
    go(4'd4);
    run(8);
`ifdef ZERO_SKIP_EN
    chk("t6_issued", 32'(issued - base), 32'd2);
`else
    chk("t6_issued", 32'(issued - base), 32'd4);
`endif
    chk("t6_done", 32'(done_cnt), 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    // 7: ena low freezes the vector mid-flight
    expect_issue(8'd31, 8'd1, 1'b1, 1'b0);
    expect_issue(8'd32, 8'd2, 1'b0, 1'b1);
    push(8'd31, 8'd1); push(8'd32, 8'd2);
    base = issued;
    go(4'd2);
    tick();
    chk("t7_first", 32'(issued - base), 32'd1);
    ena = 1'b0;
    run(3);
    chk("t7_frozen_valid", 32'(mac_valid), 32'd0);
    chk("t7_frozen_level", 32'(level), 32'd1);
    chk("t7_frozen_busy", 32'(busy), 32'd1);
    chk("t7_in_ready_off", 32'(in_ready), 32'd0);
    ena = 1'b1;
    run(4);
    chk("t7_issued", 32'(issued - base), 32'd2);
    chk("t7_idle", 32'(busy), 32'd0);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
